// File: rtl/cpu_pkg.sv
// Shared CPU constants: default datapath widths, reset vector and opcodes.
package cpu_pkg;

    localparam int unsigned CPU_ADDR_W  = 32;
    localparam int unsigned CPU_INSTR_W = 32;

    localparam logic [CPU_ADDR_W-1:0] CPU_RESET_PC = '0;

    // Primary opcode field, shared with the control unit's jump/halt decode.
    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00,
        OP_JUMP  = 6'h02,
        OP_JAL   = 6'h03,
        OP_BEQ   = 6'h04,
        OP_BNE   = 6'h05,
        OP_LW    = 6'h23,
        OP_SW    = 6'h2B,
        OP_HALT  = 6'h3F
    } opcode_e;

    // Extract the primary opcode from a full instruction word.
    function automatic opcode_e opcodeOf(input logic [CPU_INSTR_W-1:0] instr);
        return opcode_e'(instr[31:26]);
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO of {pc, instr} pairs with flush; depth must be a power of two.
module fetch_queue
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W  = CPU_ADDR_W,
    parameter int unsigned INSTR_W = CPU_INSTR_W,
    parameter int unsigned DEPTH   = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [ADDR_W-1:0]          pushPc,
    input  logic [INSTR_W-1:0]         pushInstr,
    output logic [ADDR_W-1:0]          headPc,
    output logic [INSTR_W-1:0]         headInstr,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_MASK = PTR_W'(DEPTH - 1);

    logic [ADDR_W-1:0]  pcMem    [DEPTH];
    logic [INSTR_W-1:0] instrMem [DEPTH];
    logic [PTR_W-1:0]   rdPtr;
    logic [PTR_W-1:0]   wrPtr;
    logic               doPush;
    logic               doPop;

    assign empty     = (count == '0);
    assign full      = (count == CNT_W'(DEPTH));
    assign headPc    = pcMem[rdPtr];
    assign headInstr = instrMem[rdPtr];

    // Overflow/underflow guards; the fetch side never pushes into a full queue.
    always_comb begin
        doPush = push && !full;
        doPop  = pop && !empty;
    end

    // Pointer, occupancy and storage update; flush drops everything queued.
    always_ff @(posedge clock) begin
        if (!reset) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                pcMem[i]    <= '0;
                instrMem[i] <= '0;
            end
        end else if (flush) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) begin
                pcMem[wrPtr]    <= pushPc;
                instrMem[wrPtr] <= pushInstr;
                wrPtr           <= (wrPtr + PTR_W'(1)) & PTR_MASK;
            end
            if (doPop) begin
                rdPtr <= (rdPtr + PTR_W'(1)) & PTR_MASK;
            end
            case ({doPush, doPop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC generator, one-cycle imem requester, prefetch queue.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned       ADDR_W      = CPU_ADDR_W,
    parameter int unsigned       INSTR_W     = CPU_INSTR_W,
    parameter int unsigned       PC_STEP     = 1,
    parameter logic [ADDR_W-1:0] RESET_PC    = ADDR_W'(CPU_RESET_PC),
    parameter int unsigned       QUEUE_DEPTH = 4
) (
    input  logic               clock,
    input  logic               reset,
    output logic               imem_en,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               dec_valid,
    output logic [INSTR_W-1:0] dec_instr,
    output logic [ADDR_W-1:0]  dec_pc,
    input  logic               dec_ready,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_target,
    input  logic               halt,
    output logic               halted
);

    localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH + 1);
    localparam int unsigned OCC_W = CNT_W + 1;

    logic [ADDR_W-1:0] fetchPc;
    logic [ADDR_W-1:0] inflightPc;
    logic              inflight;
    logic              issue;
    logic              push;
    logic              pop;
    logic              flush;
    logic [CNT_W-1:0]  count;
    logic              empty;
    logic              full;
    logic [OCC_W-1:0]  occupancy;

    // Issue only when the queue has room for everything already requested.
    always_comb begin
        occupancy = OCC_W'(count) + OCC_W'(inflight);
        issue     = reset && !halted && !halt && !redirect_valid && !full
                    && (occupancy < OCC_W'(QUEUE_DEPTH));
        push      = inflight && !redirect_valid;
        pop       = !empty && dec_ready;
        flush     = redirect_valid;
    end

    assign imem_en   = issue;
    assign imem_addr = fetchPc;
    assign dec_valid = !empty;

    // PC, in-flight tag and sticky halt; a redirect squashes the pending response.
    always_ff @(posedge clock) begin
        if (!reset) begin
            fetchPc    <= RESET_PC;
            inflightPc <= RESET_PC;
            inflight   <= 1'b0;
            halted     <= 1'b0;
        end else begin
            if (redirect_valid) begin
                fetchPc <= redirect_target;
            end else if (issue) begin
                fetchPc <= fetchPc + ADDR_W'(PC_STEP);
            end
            if (issue) begin
                inflightPc <= fetchPc;
            end
            inflight <= issue;
            if (halt) begin
                halted <= 1'b1;
            end
        end
    end

    fetch_queue #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W),
        .DEPTH   (QUEUE_DEPTH)
    ) queue (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .flush     (flush),
        .pushPc    (inflightPc),
        .pushInstr (imem_rdata),
        .headPc    (dec_pc),
        .headInstr (dec_instr),
        .count     (count),
        .empty     (empty),
        .full      (full)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized and directed bench for fetch_unit against a queue-level reference model.
module tb_fetch_unit;

    localparam int unsigned DEPTH = 4;

    logic        clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset;
    logic        imem_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        dec_valid;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic        dec_ready;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        halt;
    logic        halted;

    logic        reset2;
    logic        imem_en2;
    logic [3:0]  imem_addr2;
    logic [31:0] imem_rdata2 = '0;
    logic        dec_valid2;
    logic [31:0] dec_instr2;
    logic [3:0]  dec_pc2;
    logic        halted2;

    fetch_unit #(
        .ADDR_W(32), .INSTR_W(32), .PC_STEP(1), .RESET_PC(32'h0), .QUEUE_DEPTH(DEPTH)
    ) dut (
        .clock(clock), .reset(reset), .imem_en(imem_en), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .dec_valid(dec_valid), .dec_instr(dec_instr),
        .dec_pc(dec_pc), .dec_ready(dec_ready), .redirect_valid(redirect_valid),
        .redirect_target(redirect_target), .halt(halt), .halted(halted)
    );

    fetch_unit #(
        .ADDR_W(4), .INSTR_W(32), .PC_STEP(1), .RESET_PC(4'd14), .QUEUE_DEPTH(4)
    ) dut4 (
        .clock(clock), .reset(reset2), .imem_en(imem_en2), .imem_addr(imem_addr2),
        .imem_rdata(imem_rdata2), .dec_valid(dec_valid2), .dec_instr(dec_instr2),
        .dec_pc(dec_pc2), .dec_ready(1'b1), .redirect_valid(1'b0),
        .redirect_target(4'd0), .halt(1'b0), .halted(halted2)
    );

    // Instruction memory contents as a function of address.
    function automatic logic [31:0] word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1234_5678;
    endfunction

    // Synchronous memories: data appears the cycle after the request.
    always @(posedge clock) if (imem_en)  imem_rdata  <= word(imem_addr);
    always @(posedge clock) if (imem_en2) imem_rdata2 <= {28'hABCDEF0, imem_addr2};

    int vectors     = 0;
    int miscompares = 0;
    bit started     = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what decode should see, what is requested, what is pending.
    typedef struct packed { logic [31:0] pc; logic [31:0] instr; } entry_t;
    entry_t      mq[$];
    logic [31:0] mFetchPc  = '0;
    logic [31:0] mFlightPc = '0;
    bit          mFlight   = 1'b0;
    bit          mHalted   = 1'b0;

    function automatic bit expIssue();
        return reset && !mHalted && !halt && !redirect_valid
               && ((mq.size() + (mFlight ? 1 : 0)) < int'(DEPTH));
    endfunction

    // Model advance at each rising edge from the inputs held during the cycle.
    always @(posedge clock) begin
        bit iss;
        iss = expIssue();
        if (!reset) begin
            mq.delete();
            mFlight  = 1'b0;
            mFetchPc = '0;
            mHalted  = 1'b0;
        end else if (redirect_valid) begin
            mq.delete();
            mFlight  = 1'b0;
            mFetchPc = redirect_target;
            if (halt) mHalted = 1'b1;
        end else begin
            if (mq.size() > 0 && dec_ready) void'(mq.pop_front());
            if (mFlight) mq.push_back('{pc: mFlightPc, instr: word(mFlightPc)});
            mFlight = iss;
            if (iss) begin
                mFlightPc = mFetchPc;
                mFetchPc  = mFetchPc + 32'd1;
            end
            if (halt) mHalted = 1'b1;
        end
    end

    // Every-cycle comparison of the main DUT against the model.
    always @(negedge clock) begin
        if (started) begin
            check("imem_en", {63'd0, imem_en}, {63'd0, expIssue()});
            if (expIssue()) check("imem_addr", 64'(imem_addr), 64'(mFetchPc));
            check("dec_valid", {63'd0, dec_valid}, {63'd0, (mq.size() > 0)});
            if (mq.size() > 0) begin
                check("dec_pc", 64'(dec_pc), 64'(mq[0].pc));
                check("dec_instr", 64'(dec_instr), 64'(mq[0].instr));
            end
            check("halted", {63'd0, halted}, {63'd0, mHalted});
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic doReset();
        reset          = 1'b0;
        redirect_valid = 1'b0;
        halt           = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        int n;
        int en;
        bit found;
        logic [31:0] addr;

        reset = 1'b0; reset2 = 1'b0; dec_ready = 1'b1;
        redirect_valid = 1'b0; redirect_target = '0; halt = 1'b0;
        tick(); tick();
        started = 1'b1;

        // Reset state.
        @(negedge clock);
        check("rst_imem_en", {63'd0, imem_en}, 64'd0);
        check("rst_imem_addr", 64'(imem_addr), 64'd0);
        check("rst_dec_valid", {63'd0, dec_valid}, 64'd0);
        check("rst_dec_pc", 64'(dec_pc), 64'd0);
        check("rst_dec_instr", 64'(dec_instr), 64'd0);
        check("rst_halted", {63'd0, halted}, 64'd0);

        // Streaming after release: first instruction two cycles later.
        tick(); reset = 1'b1;
        @(negedge clock);
        check("c0_en", {63'd0, imem_en}, 64'd1);
        check("c0_addr", 64'(imem_addr), 64'd0);
        tick(); @(negedge clock);
        check("c1_addr", 64'(imem_addr), 64'd1);
        check("c1_valid", {63'd0, dec_valid}, 64'd0);
        for (int i = 0; i < 6; i++) begin
            tick(); @(negedge clock);
            check("stream_valid", {63'd0, dec_valid}, 64'd1);
            check("stream_pc", 64'(dec_pc), 64'(i));
            check("stream_instr", 64'(dec_instr), 64'(word(32'(i))));
        end

        // Stall: four fetches then stop, head holds, resume at pc 4.
        tick(); doReset(); dec_ready = 1'b0; reset = 1'b1;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            if (imem_en) n++;
            tick();
        end
        check("stall_issue_count", 64'(n), 64'd4);
        @(negedge clock);
        check("stall_head_pc", 64'(dec_pc), 64'd0);
        tick(); dec_ready = 1'b1;
        found = 1'b0; addr = '0;
        for (int i = 0; i < 6 && !found; i++) begin
            @(negedge clock);
            if (imem_en) begin found = 1'b1; addr = imem_addr; end
            tick();
        end
        check("resume_seen", {63'd0, found}, 64'd1);
        check("resume_addr", 64'(addr), 64'd4);
        repeat (8) tick();

        // Redirect with three queued and one in flight.
        doReset(); dec_ready = 1'b0; reset = 1'b1;
        repeat (4) tick();
        redirect_valid = 1'b1; redirect_target = 32'h40;
        @(negedge clock);
        check("redir_cycle_en", {63'd0, imem_en}, 64'd0);
        tick(); redirect_valid = 1'b0;
        @(negedge clock);
        check("redir_n1_valid", {63'd0, dec_valid}, 64'd0);
        check("redir_n1_en", {63'd0, imem_en}, 64'd1);
        check("redir_n1_addr", 64'(imem_addr), 64'h40);
        tick(); @(negedge clock);
        check("redir_n2_valid", {63'd0, dec_valid}, 64'd0);
        tick(); @(negedge clock);
        check("redir_n3_valid", {63'd0, dec_valid}, 64'd1);
        check("redir_n3_pc", 64'(dec_pc), 64'h40);
        tick(); dec_ready = 1'b1;
        repeat (6) tick();

        // Halt mid-stream: no more issue, queue and in-flight drain.
        doReset(); dec_ready = 1'b1; reset = 1'b1;
        repeat (5) tick();
        halt = 1'b1;
        n = 0; en = 0;
        @(negedge clock);
        check("halt_cycle_en", {63'd0, imem_en}, 64'd0);
        if (dec_valid && dec_ready) n++;
        tick(); halt = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clock);
            if (imem_en) en++;
            if (dec_valid && dec_ready) n++;
            tick();
        end
        check("halt_drained", 64'(n), 64'd2);
        check("halt_no_issue", 64'(en), 64'd0);
        @(negedge clock);
        check("halt_sticky", {63'd0, halted}, 64'd1);
        check("halt_empty", {63'd0, dec_valid}, 64'd0);
        tick(); reset = 1'b0; tick(); tick();
        @(negedge clock);
        check("halt_cleared", {63'd0, halted}, 64'd0);
        tick(); reset = 1'b1;
        @(negedge clock);
        check("halt_restart_en", {63'd0, imem_en}, 64'd1);
        check("halt_restart_addr", 64'(imem_addr), 64'd0);

        // Reset with full queue and a simultaneous redirect.
        tick(); doReset(); dec_ready = 1'b0; reset = 1'b1;
        repeat (6) tick();
        @(negedge clock);
        check("full_before_reset", {63'd0, dec_valid}, 64'd1);
        tick(); reset = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h99;
        tick(); redirect_valid = 1'b0;
        @(negedge clock);
        check("rr_valid", {63'd0, dec_valid}, 64'd0);
        check("rr_en", {63'd0, imem_en}, 64'd0);
        tick(); reset = 1'b1;
        @(negedge clock);
        check("rr_restart_en", {63'd0, imem_en}, 64'd1);
        check("rr_restart_addr", 64'(imem_addr), 64'd0);
        tick(); dec_ready = 1'b1;

        // Randomized traffic: backpressure, redirects (some near wrap), halts, resets.
        for (int i = 0; i < 3000; i++) begin
            dec_ready       = ($urandom_range(9) < 7);
            redirect_valid  = ($urandom_range(31) == 0);
            redirect_target = ($urandom_range(3) == 0) ? 32'hFFFF_FFFE : $urandom;
            halt            = ($urandom_range(399) == 0);
            reset           = ($urandom_range(299) != 0);
            tick();
        end
        reset = 1'b1; redirect_valid = 1'b0; halt = 1'b0;
        tick();

        // Narrow-address instance: wrap from 15 to 0.
        reset2 = 1'b1;
        @(negedge clock);
        check("w4_c0_addr", 64'(imem_addr2), 64'd14);
        check("w4_c0_en", {63'd0, imem_en2}, 64'd1);
        tick(); @(negedge clock);
        check("w4_c1_addr", 64'(imem_addr2), 64'd15);
        tick(); @(negedge clock);
        check("w4_c2_addr", 64'(imem_addr2), 64'd0);
        check("w4_c2_valid", {63'd0, dec_valid2}, 64'd1);
        check("w4_c2_pc", 64'(dec_pc2), 64'd14);
        tick(); @(negedge clock);
        check("w4_c3_addr", 64'(imem_addr2), 64'd1);
        check("w4_c3_pc", 64'(dec_pc2), 64'd15);
        check("w4_c3_instr", 64'(dec_instr2), 64'hABCDEF0F);
        tick(); @(negedge clock);
        check("w4_c4_pc", 64'(dec_pc2), 64'd0);
        tick(); @(negedge clock);
        check("w4_c5_pc", 64'(dec_pc2), 64'd1);
        check("w4_c5_instr", 64'(dec_instr2), 64'hABCDEF01);
        check("w4_halted", {63'd0, halted2}, 64'd0);

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Parametrised instruction-fetch front end that replaces the bare PC register with a PC generator, a synchronous instruction-memory requester and a prefetch queue. It sits between the instruction memory and the control unit / register-bank decode. Decode is decoupled through a valid/ready handshake, so downstream stalls no longer freeze the PC. Branch and jump redirects flush all prefetched work. Halt stops fetching until reset.

Parameters:
ADDR_W, 32, program-counter and instruction-memory address width
INSTR_W, 32, instruction word width
PC_STEP, 1, PC increment per sequential fetch (word-addressed memory)
RESET_PC, 0, PC loaded on reset
QUEUE_DEPTH, 4, prefetch queue entries; power of two, at least 2

Ports:
clock  in  1  single system clock; all state updates on rising edge
reset  in  1  synchronous, active-low reset
imem_en  out  1  fetch request to instruction memory this cycle
imem_addr  out  ADDR_W  fetch address; memory returns data one cycle later
imem_rdata  in  INSTR_W  instruction for the request issued in the previous cycle
dec_valid  out  1  queue head holds a valid instruction
dec_instr  out  INSTR_W  queue-head instruction
dec_pc  out  ADDR_W  PC of the queue-head instruction
dec_ready  in  1  decode consumes the head when dec_valid is also 1
redirect_valid  in  1  branch taken or jump, from execute/control
redirect_target  in  ADDR_W  new PC
halt  in  1  halt request from the control unit
halted  out  1  sticky halt status

Behaviour:
- Reset (reset==0 at an edge):
  - fetch_pc=RESET_PC, queue empty, in-flight cleared, halted=0.
  - Outputs: imem_en=0, imem_addr=RESET_PC, dec_valid=0, dec_instr=0, dec_pc=0.
  - Reset wins over every other input.
- Issue rule: imem_en=1 when all of the following hold:
  - not halted;
  - redirect_valid==0;
  - (count + inflight) < QUEUE_DEPTH. The in-flight request reserves a slot, so the queue can never overflow.
- When issuing: imem_addr=fetch_pc, and fetch_pc advances by PC_STEP modulo 2^ADDR_W. A wrap from all-ones to 0 is legal and silent.
- Memory latency is one cycle:
  - A request issued in cycle N is captured with its PC into the queue at the end of cycle N+1.
  - dec_valid is asserted from cycle N+2. There is no bypass.
  - After reset release, the first instruction is visible 2 cycles later. Steady-state throughput is 1 instruction per cycle.
- Dequeue happens when dec_valid && dec_ready. A push and a pop in the same cycle are allowed; count is unchanged.
- With dec_ready held low, the queue fills to QUEUE_DEPTH and issue stops. The head is stable: dec_instr and dec_pc do not change while dec_valid && !dec_ready.
- Redirect (redirect_valid==1 at an edge):
  - queue flushed, count=0;
  - any in-flight response is discarded (its capture is squashed);
  - fetch_pc=redirect_target;
  - no issue during the redirect cycle;
  - target issued the next cycle and presented on dec 3 cycles after the redirect cycle.
  - A pop in the same cycle has no further effect. Back-to-back redirects: the last one wins.
- Halt:
  - halt==1 at an edge sets halted=1 until reset.
  - No issue occurs in the halt cycle or after it.
  - The in-flight response is still captured and the queue still drains to decode.
  - A redirect while halted updates fetch_pc and flushes the queue, but fetches nothing.
- Priority: reset > redirect > halt > issue/push/pop.
- Address and data are unsigned; no arithmetic beyond the PC increment.

Decomposition:
- Shared package cpu_pkg holds:
  - default widths: ADDR_W and INSTR_W of 32;
  - RESET_PC;
  - the opcode constants already used by the control unit, so control-unit halt and jump decoding and this block agree.
- One natural sub-module, fetch_queue:
  - synchronous FIFO of {pc, instr};
  - inputs push, pop and flush;
  - outputs count, empty and full;
  - depth = QUEUE_DEPTH;
  - pointer wrap by power-of-two masking.
- The PC, in-flight tracking and halt logic stay in fetch_unit.

Test Plan:
- Reset, then release with dec_ready=1 and memory returning word=address. Required:
  - imem_addr sequence is 0,1,2,3…;
  - dec_valid first rises 2 cycles after release;
  - dec_pc/dec_instr are 0,1,2… with one instruction per cycle.
- Hold dec_ready=0 with QUEUE_DEPTH=4. Required:
  - exactly 4 fetches issued, then imem_en=0;
  - head stays pc=0;
  - after raising dec_ready, issue resumes at pc=4 and no instruction is lost or duplicated.
- Pulse redirect_valid with target=0x40 while 3 entries are queued and 1 is in flight. Required:
  - dec_valid=0 the next cycle;
  - the next issue is 0x40;
  - dec_pc=0x40 appears 3 cycles after the redirect, and no stale PCs are ever presented.
- Assert halt for one cycle mid-stream. Required:
  - halted=1 stays set;
  - no imem_en afterwards;
  - the queued and in-flight instructions still drain;
  - only reset clears the halted state and restarts fetch at RESET_PC.
- Set ADDR_W=4 and start at pc=14. Required: the fetch sequence is 14,15,0,1, with the correct dec_pc tags.
- Assert reset mid-stream with the queue full and a redirect asserted in the same cycle. Required: reset wins, giving an empty queue, dec_valid=0 and a restart from RESET_PC.
